// File: rtl/bikelight_pkg.sv
// Shared mode encoding and counter sizing for the bike-light controller.
package bikelight_pkg;

    typedef enum logic [3:0] {
        MODE_OFF   = 4'b0001,
        MODE_ON    = 4'b0010,
        MODE_BLINK = 4'b0100,
        MODE_DIM   = 4'b1000
    } mode_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and stable-count debouncer for a raw push-button.
module btn_debounce
    import bikelight_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = cnt_w(DEB_CYCLES);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 2");
    end

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                cnt_q <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bikelight_ctrl.sv
// Four-mode bike-light FSM with blink and PWM dimming; define
// BIKELIGHT_LONG_PRESS_EN to add the hold-to-switch-off feature.
module bikelight_ctrl
    import bikelight_pkg::*;
#(
    parameter int NUM_LEDS    = 1,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int BLINK_HALF  = 25_000_000,
    parameter int PWM_W       = 8,
    parameter int DIM_DUTY    = 32,
    parameter int LONG_CYCLES = 200_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn,
    output logic [NUM_LEDS-1:0] led,
    output logic [3:0]          state
);

    localparam int BW = cnt_w(BLINK_HALF);
    localparam logic [PWM_W:0] DUTY = (PWM_W + 1)'(DIM_DUTY);

    if (BLINK_HALF < 1 || LONG_CYCLES < 1) begin : g_bad_cfg
        $error("BLINK_HALF and LONG_CYCLES must be at least 1");
    end

    mode_t               state_q, state_d;
    logic [BW-1:0]       blink_q, blink_d;
    logic                phase_q, phase_d;
    logic [PWM_W-1:0]    pwm_q, pwm_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                level;
    logic                press;
    logic                force_off;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .level(level),
        .press(press)
    );

`ifdef BIKELIGHT_LONG_PRESS_EN
    localparam int LW = cnt_w(LONG_CYCLES + 1);

    logic [LW-1:0] long_q;

    // Saturates one past the trigger value so the force fires once per hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_q <= '0;
        end else if (!level) begin
            long_q <= '0;
        end else if (long_q != LW'(LONG_CYCLES)) begin
            long_q <= long_q + 1'b1;
        end
    end

    assign force_off = level && (long_q == LW'(LONG_CYCLES - 1));
`else
    assign force_off = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (press) begin
            unique case (1'b1)
                state_q[0]: state_d = MODE_ON;
                state_q[1]: state_d = MODE_BLINK;
                state_q[2]: state_d = MODE_DIM;
                state_q[3]: state_d = MODE_OFF;
                default:    state_d = MODE_OFF;
            endcase
        end
        if (force_off) begin
            state_d = MODE_OFF;
        end
    end

    always_comb begin
        blink_d = '0;
        phase_d = 1'b0;
        pwm_d   = '0;
        if (state_d == MODE_BLINK) begin
            phase_d = 1'b1;
            if (state_q == MODE_BLINK) begin
                if (blink_q == BW'(BLINK_HALF - 1)) begin
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                    phase_d = phase_q;
                end
            end
        end
        if (state_d == MODE_DIM && state_q == MODE_DIM) begin
            pwm_d = pwm_q + 1'b1;
        end
        led_d = '0;
        unique case (1'b1)
            state_d[0]: led_d = '0;
            state_d[1]: led_d = '1;
            state_d[2]: led_d = {NUM_LEDS{phase_d}};
            state_d[3]: led_d = {NUM_LEDS{({1'b0, pwm_d} < DUTY)}};
            default:    led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_OFF;
            blink_q <= '0;
            phase_q <= 1'b0;
            pwm_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
        end
    end

    assign led   = led_q;
    assign state = state_q;

endmodule

// File: tb/tb_bikelight_ctrl.sv
// Directed plus random button stimulus against a behavioural light model.
module tb_bikelight_ctrl;

    localparam int DEB  = 4;
    localparam int BH   = 8;
    localparam int PW   = 4;
    localparam int LONG = 20;
    localparam int NL   = 3;

    logic          clk;
    logic          rst_n;
    logic          btn;
    logic [NL-1:0] led, led0, led16;
    logic [3:0]    state, state0, state16;

    int n_cmp;
    int n_bad;

    bikelight_ctrl #(
        .NUM_LEDS(NL), .DEB_CYCLES(DEB), .BLINK_HALF(BH),
        .PWM_W(PW), .DIM_DUTY(4), .LONG_CYCLES(LONG)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .led(led), .state(state)
    );

    bikelight_ctrl #(
        .NUM_LEDS(NL), .DEB_CYCLES(DEB), .BLINK_HALF(BH),
        .PWM_W(PW), .DIM_DUTY(0), .LONG_CYCLES(LONG)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .led(led0), .state(state0)
    );

    bikelight_ctrl #(
        .NUM_LEDS(NL), .DEB_CYCLES(DEB), .BLINK_HALF(BH),
        .PWM_W(PW), .DIM_DUTY(16), .LONG_CYCLES(LONG)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .led(led16), .state(state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode index 0..3, cycles since mode entry,
    // debounced level derived from the last DEB synchronised samples.
    bit bq[$];
    bit syn_q[$];
    bit m_lvl;
    bit m_press;
    int m_mode;
    int m_t;
    int m_hcnt;

    task automatic model_reset();
        bq.delete();
        syn_q.delete();
        m_lvl   = 1'b0;
        m_press = 1'b0;
        m_mode  = 0;
        m_t     = 0;
        m_hcnt  = 0;
    endtask

    task automatic model_edge(input bit b);
        bit syn;
        bit all;
        int prev;
        bq.push_back(b);
        if (bq.size() > 4) void'(bq.pop_front());
        syn  = (bq.size() >= 3) ? bq[bq.size() - 3] : 1'b0;
        prev = m_mode;
        if (m_press) m_mode = (m_mode + 1) % 4;
`ifdef BIKELIGHT_LONG_PRESS_EN
        if (!m_lvl) begin
            m_hcnt = 0;
        end else if (m_hcnt < LONG) begin
            m_hcnt++;
            if (m_hcnt == LONG) m_mode = 0;
        end
`endif
        m_t = (m_mode != prev) ? 0 : m_t + 1;
        m_press = 1'b0;
        syn_q.push_back(syn);
        if (syn_q.size() > DEB) void'(syn_q.pop_front());
        if (syn_q.size() == DEB) begin
            all = 1'b1;
            foreach (syn_q[i]) if (syn_q[i] == m_lvl) all = 1'b0;
            if (all) begin
                m_lvl   = !m_lvl;
                m_press = m_lvl;
            end
        end
    endtask

    function automatic logic [3:0] exp_led(input int duty);
        case (m_mode)
            1:       return 4'b0111;
            2:       return ((m_t / BH) % 2 == 0) ? 4'b0111 : 4'b0000;
            3:       return ((m_t % 16) < duty) ? 4'b0111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] es;
        es = 4'(1 << m_mode);
        chk("state", state, es);
        chk("state_d0", state0, es);
        chk("state_d16", state16, es);
        chk("led", {1'b0, led}, exp_led(4));
        chk("led_d0", {1'b0, led0}, exp_led(0));
        chk("led_d16", {1'b0, led16}, exp_led(16));
    endtask

    task automatic cyc(input bit b);
        @(negedge clk);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check_all();
    endtask

    task automatic press_clean();
        repeat (8) cyc(1'b1);
        repeat (8) cyc(1'b0);
    endtask

    initial begin
        int  edge_hit;
        int  len;
        bit  v;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        btn   = 1'b0;
        model_reset();

        // Button activity while held in reset must not leak through.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn = i[0];
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        btn   = 1'b0;
        rst_n = 1'b1;

        // First press: state moves on edge DEB+3 = 7.
        edge_hit = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1);
            if (edge_hit == 0 && state !== 4'b0001) edge_hit = i;
        end
        chk("press_latency", 4'(edge_hit), 4'd7);
        repeat (10) cyc(1'b0);
        chk("after_first", state, 4'b0010);

        press_clean();
        repeat (50) cyc(1'b0);
        chk("in_blink", state, 4'b0100);
        press_clean();
        repeat (40) cyc(1'b0);
        chk("in_dim", state, 4'b1000);
        press_clean();
        chk("wrap_off", state, 4'b0001);

        // Short bounces are rejected.
        repeat (3) cyc(1'b1);
        cyc(1'b0);
        repeat (3) cyc(1'b1);
        repeat (12) cyc(1'b0);
        chk("bounce", state, 4'b0001);

        // Asynchronous reset in the middle of BLINK.
        press_clean();
        press_clean();
        repeat (5) cyc(1'b0);
        @(posedge clk);
        model_edge(1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_state", state, 4'b0001);
        chk("async_led", {1'b0, led}, 4'b0000);
        chk("async_led16", {1'b0, led16}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Long hold from BLINK.
        press_clean();
        press_clean();
        repeat (4) cyc(1'b0);
        repeat (40) cyc(1'b1);
`ifdef BIKELIGHT_LONG_PRESS_EN
        chk("long_hold", state, 4'b0001);
`else
        chk("long_hold", state, 4'b1000);
`endif
        repeat (20) cyc(1'b0);
`ifdef BIKELIGHT_LONG_PRESS_EN
        chk("long_release", state, 4'b0001);
`else
        chk("long_release", state, 4'b1000);
`endif

        // Random presses, holds and glitches.
        v = 1'b0;
        for (int s = 0; s < 140; s++) begin
            v   = ~v;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(25, 45)
                                              : $urandom_range(1, 12);
            repeat (len) cyc(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
